// File: rtl/cpu_pkg.sv
// Shared constants and types for the RV32I core front end.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC candidates: sequential PC+4 and the execute-stage redirect target.
module next_pc_sel #(
    parameter int A_WIDTH = 32
) (
    input  logic [A_WIDTH-1:0] pc,
    input  logic               jalr_sel,
    input  logic [A_WIDTH-1:0] pc_target,
    input  logic [A_WIDTH-1:0] alu_result,
    output logic [A_WIDTH-1:0] pc_plus4,
    output logic [A_WIDTH-1:0] redirect_target
);

    assign pc_plus4 = pc + A_WIDTH'(4);

    // Only bit 0 is cleared for JALR; a set bit 1 is fetched misaligned on purpose.
    assign redirect_target = jalr_sel ? {alu_result[A_WIDTH-1:1], 1'b0} : pc_target;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer and redirect handling.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                 D_WIDTH  = 32,
    parameter int                 A_WIDTH  = 32,
    parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               StallF,
    input  logic               FlushD,
    input  logic               PCSrcE,
    input  logic               JALRctrlE,
    input  logic [A_WIDTH-1:0] PCTargetE,
    input  logic [A_WIDTH-1:0] ALUResultE,
    output logic               imem_req,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic [D_WIDTH-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [D_WIDTH-1:0] InstrD,
    output logic [A_WIDTH-1:0] PCD,
    output logic [A_WIDTH-1:0] PCPlus4D,
    output logic               ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        FetchCount,
    output logic [31:0]        RedirectCount,
    output logic [31:0]        StallCycles
`endif
);

    fetch_state_t       state_reg;
    logic [A_WIDTH-1:0] pc_reg;
    logic [A_WIDTH-1:0] pending_reg;
    logic [D_WIDTH-1:0] skid_instr_reg;
    logic [A_WIDTH-1:0] skid_pc_reg;
    logic [D_WIDTH-1:0] instr_d_reg;
    logic [A_WIDTH-1:0] pc_d_reg;
    logic [A_WIDTH-1:0] pc_plus4_d_reg;
    logic               valid_d_reg;

    logic [A_WIDTH-1:0] pc_plus4;
    logic [A_WIDTH-1:0] redirect_target;
    logic               id_load;
    logic               id_hold;

    next_pc_sel #(
        .A_WIDTH (A_WIDTH)
    ) u_next_pc_sel (
        .pc              (pc_reg),
        .jalr_sel        (JALRctrlE),
        .pc_target       (PCTargetE),
        .alu_result      (ALUResultE),
        .pc_plus4        (pc_plus4),
        .redirect_target (redirect_target)
    );

    assign imem_req  = (state_reg != HOLD);
    assign imem_addr = pc_reg;
    assign InstrD    = instr_d_reg;
    assign PCD       = pc_d_reg;
    assign PCPlus4D  = pc_plus4_d_reg;
    assign ValidD    = valid_d_reg;

    // Redirect and flush win over stall; anything neither loaded nor held becomes a bubble.
    always_comb begin
        id_hold = StallF && !PCSrcE && !FlushD;
        id_load = !StallF && !PCSrcE && !FlushD &&
                  ((state_reg == FETCH && imem_valid) || state_reg == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            pending_reg    <= '0;
            skid_instr_reg <= '0;
            skid_pc_reg    <= '0;
            instr_d_reg    <= D_WIDTH'(NOP_INSTR);
            pc_d_reg       <= '0;
            pc_plus4_d_reg <= '0;
            valid_d_reg    <= 1'b0;
        end else begin
            if (id_load) begin
                if (state_reg == HOLD) begin
                    instr_d_reg    <= skid_instr_reg;
                    pc_d_reg       <= skid_pc_reg;
                    pc_plus4_d_reg <= pc_reg;
                end else begin
                    instr_d_reg    <= imem_rdata;
                    pc_d_reg       <= pc_reg;
                    pc_plus4_d_reg <= pc_plus4;
                end
                valid_d_reg <= 1'b1;
            end else if (!id_hold) begin
                instr_d_reg    <= D_WIDTH'(NOP_INSTR);
                pc_d_reg       <= '0;
                pc_plus4_d_reg <= '0;
                valid_d_reg    <= 1'b0;
            end

            case (state_reg)
                FETCH: begin
                    if (PCSrcE) begin
                        if (imem_valid) begin
                            pc_reg <= redirect_target;
                        end else begin
                            pending_reg <= redirect_target;
                            state_reg   <= DROP;
                        end
                    end else if (imem_valid) begin
                        pc_reg <= pc_plus4;
                        if (StallF) begin
                            skid_instr_reg <= imem_rdata;
                            skid_pc_reg    <= pc_reg;
                            state_reg      <= HOLD;
                        end
                    end
                end
                // The outstanding request must still complete before the new target is issued.
                DROP: begin
                    if (imem_valid) begin
                        pc_reg    <= PCSrcE ? redirect_target : pending_reg;
                        state_reg <= FETCH;
                    end else if (PCSrcE) begin
                        pending_reg <= redirect_target;
                    end
                end
                HOLD: begin
                    if (PCSrcE) begin
                        pc_reg    <= redirect_target;
                        state_reg <= FETCH;
                    end else if (!StallF) begin
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [2:0]       perf_inc;
    logic [2:0][31:0] perf_cnt;

    assign perf_inc = {StallF, PCSrcE, (state_reg == FETCH) && imem_valid && !PCSrcE};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (perf_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
            assign perf_cnt[gi] = cnt_reg;
        end
    endgenerate

    assign FetchCount    = perf_cnt[0];
    assign RedirectCount = perf_cnt[1];
    assign StallCycles   = perf_cnt[2];
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random hazards against a transaction-level model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, FlushD, PCSrcE, JALRctrlE;
    logic [31:0] PCTargetE, ALUResultE;
    logic        imem_req, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    logic        w_zero = 1'b0;
    logic        w_valid = 1'b1;
    logic [31:0] w_zero32 = 32'h0;
    logic [31:0] w_rdata = 32'hCAFE_0001;
    logic        w_req, w_validd;
    logic [31:0] w_addr, w_instrd, w_pcd, w_pcp4d;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, redir_cnt, stall_cnt;
    logic [31:0] w_fetch_cnt, w_redir_cnt, w_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    initial forever #5 clk = ~clk;

    fetch_stage dut (
        .clk (clk), .rst (rst), .StallF (StallF), .FlushD (FlushD),
        .PCSrcE (PCSrcE), .JALRctrlE (JALRctrlE), .PCTargetE (PCTargetE), .ALUResultE (ALUResultE),
        .imem_req (imem_req), .imem_addr (imem_addr), .imem_rdata (imem_rdata), .imem_valid (imem_valid),
        .InstrD (InstrD), .PCD (PCD), .PCPlus4D (PCPlus4D), .ValidD (ValidD)
`ifdef FETCH_PERF_EN
        , .FetchCount (fetch_cnt), .RedirectCount (redir_cnt), .StallCycles (stall_cnt)
`endif
    );

    fetch_stage #(.RESET_PC (32'hFFFF_FFFC)) dut_wrap (
        .clk (clk), .rst (rst), .StallF (w_zero), .FlushD (w_zero),
        .PCSrcE (w_zero), .JALRctrlE (w_zero), .PCTargetE (w_zero32), .ALUResultE (w_zero32),
        .imem_req (w_req), .imem_addr (w_addr), .imem_rdata (w_rdata), .imem_valid (w_valid),
        .InstrD (w_instrd), .PCD (w_pcd), .PCPlus4D (w_pcp4d), .ValidD (w_validd)
`ifdef FETCH_PERF_EN
        , .FetchCount (w_fetch_cnt), .RedirectCount (w_redir_cnt), .StallCycles (w_stall_cnt)
`endif
    );

    // Reference model: instruction memory contents, current fetch PC, pending discard, skid entries.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } skid_t;

    logic [31:0] m_pc, m_drop_tgt;
    bit          m_dropping;
    skid_t       m_skid[$];
    logic [31:0] e_instr, e_pc, e_pc4;
    bit          e_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s (cyc %0d): got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = 32'h0;
        m_drop_tgt = 32'h0;
        m_dropping = 1'b0;
        m_skid.delete();
        e_instr    = NOP;
        e_pc       = 32'h0;
        e_pc4      = 32'h0;
        e_valid    = 1'b0;
    endtask

    task automatic model_step(input bit st, fl, ps, jr, input logic [31:0] tg, alu, input bit vl);
        logic [31:0] tgt;
        bit          busy;
        tgt  = jr ? {alu[31:1], 1'b0} : tg;
        busy = (m_skid.size() != 0);
        if (ps || fl) begin
            e_instr = NOP; e_pc = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
        end else if (!st) begin
            if (busy) begin
                e_instr = m_skid[0].instr; e_pc = m_skid[0].pc; e_pc4 = m_skid[0].pc + 32'd4; e_valid = 1'b1;
            end else if (!m_dropping && vl) begin
                e_instr = mem_word(m_pc); e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_valid = 1'b1;
            end else begin
                e_instr = NOP; e_pc = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
            end
        end
        if (busy) begin
            if (ps) begin
                m_skid.delete();
                m_pc = tgt;
            end else if (!st) begin
                m_skid.delete();
            end
        end else if (m_dropping) begin
            if (ps) m_drop_tgt = tgt;
            if (vl) begin
                m_pc       = m_drop_tgt;
                m_dropping = 1'b0;
            end
        end else if (ps) begin
            if (vl) m_pc = tgt;
            else begin
                m_dropping = 1'b1;
                m_drop_tgt = tgt;
            end
        end else if (vl) begin
            if (st) m_skid.push_back('{instr: mem_word(m_pc), pc: m_pc});
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_outputs();
        check_val("imem_req", 32'(imem_req), 32'(m_skid.size() == 0));
        check_val("imem_addr", imem_addr, m_pc);
        check_val("InstrD", InstrD, e_instr);
        check_val("PCD", PCD, e_pc);
        check_val("PCPlus4D", PCPlus4D, e_pc4);
        check_val("ValidD", 32'(ValidD), 32'(e_valid));
        $display("cyc %0d req=%b addr=%h ValidD=%b PCD=%h InstrD=%h", cyc, imem_req, imem_addr, ValidD, PCD, InstrD);
    endtask

    task automatic step(input bit st, fl, ps, jr, input logic [31:0] tg, alu, input bit vl);
        StallF     = st;
        FlushD     = fl;
        PCSrcE     = ps;
        JALRctrlE  = jr;
        PCTargetE  = tg;
        ALUResultE = alu;
        imem_valid = vl;
        imem_rdata = vl ? mem_word(m_pc) : $urandom;
        model_step(st, fl, ps, jr, tg, alu, vl);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            StallF = 1'($urandom); FlushD = 1'($urandom); PCSrcE = 1'($urandom);
            imem_valid = 1'($urandom); imem_rdata = $urandom;
            @(negedge clk);
            cyc++;
        end
        model_reset();
        check_outputs();
        rst = 1'b0;
        StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; imem_valid = 1'b0;
        check_val("req_after_rst", 32'(imem_req), 32'd1);
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; JALRctrlE = 1'b0;
        PCTargetE = '0; ALUResultE = '0; imem_valid = 1'b0; imem_rdata = '0;
        do_reset(2);
        check_val("wrap_first_addr", w_addr, 32'hFFFF_FFFC);

        // Back-to-back single-cycle responses.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            check_val("seq_pcd", PCD, 32'(i * 4));
            check_val("seq_valid", 32'(ValidD), 32'd1);
            if (i == 0) begin
                check_val("wrap_second_addr", w_addr, 32'h0);
                check_val("wrap_pcd", w_pcd, 32'hFFFF_FFFC);
                check_val("wrap_pcplus4d", w_pcp4d, 32'h0);
            end
`ifdef FETCH_PERF_EN
            if (i == 1) check_val("wrap_fetch_count", w_fetch_cnt, 32'd2);
`endif
        end

        // Branch while a request is outstanding.
        step(0, 0, 1, 0, 32'h40, 0, 0);
        check_val("br_bubble", 32'(ValidD), 32'd0);
        check_val("br_stale_addr", imem_addr, 32'h10);
        step(0, 0, 0, 0, 0, 0, 1);
        check_val("br_new_addr", imem_addr, 32'h40);
        check_val("br_drop_bubble", 32'(ValidD), 32'd0);
        step(0, 0, 0, 0, 0, 0, 1);
        check_val("br_target_pcd", PCD, 32'h40);

        // JALR target clears bit 0 only.
        step(0, 0, 1, 1, 0, 32'h0000_0123, 1);
        check_val("jalr_addr", imem_addr, 32'h122);
        step(0, 0, 0, 0, 0, 0, 1);
        check_val("jalr_pcd", PCD, 32'h122);

        // Stall while a response arrives.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 1);
            check_val("stall_req", 32'(imem_req), 32'd0);
            check_val("stall_pcd", PCD, 32'h122);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        check_val("release_pcd", PCD, 32'h126);
        check_val("release_instr", InstrD, mem_word(32'h126));
        check_val("release_addr", imem_addr, 32'h12A);

        // Redirect while holding a buffered instruction.
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 32'h80, 0, 1);
        check_val("hold_redir_addr", imem_addr, 32'h80);
        check_val("hold_redir_valid", 32'(ValidD), 32'd0);
        check_val("hold_redir_req", 32'(imem_req), 32'd1);

        // Random hazards and memory latency, with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tg;
            tg = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
            if (i == 200) do_reset(1 + int'($urandom_range(0, 1)));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 6) == 0,
                 1'($urandom), tg, $urandom, $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
